// File: rtl/mux_pc_src_if.sv
// mux_pc_src_if: next-PC select bus between the datapath control and the mux_pc_src stage.
interface mux_pc_src_if #(
    parameter int WIDTH       = 32,
    parameter int COUNT_WIDTH = 16
);
    logic [WIDTH-1:0]       add_result;
    logic [WIDTH-1:0]       pc4;
    logic                   controle;
    logic [WIDTH-1:0]       saida_pc;
    logic                   sel_q;
    logic [COUNT_WIDTH-1:0] taken_count;
    logic                   misaligned;
    modport master (
        output add_result, pc4, controle,
        input  saida_pc, sel_q, taken_count, misaligned
    );
    modport slave (
        input  add_result, pc4, controle,
        output saida_pc, sel_q, taken_count, misaligned
    );
endinterface

// File: rtl/mux_pc_src.sv
// mux_pc_src: registered PCSrc select (pc4 vs branch target) with a saturating taken counter.
// Define PCSRC_ALIGN_CHECK_EN to word-align saida_pc and flag misaligned targets.
module mux_pc_src #(
    parameter int          WIDTH       = 32,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
    parameter int          COUNT_WIDTH = 16
) (
    input logic          clk,
    input logic          rst_n,
    mux_pc_src_if.slave  bus
);
    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VALUE);
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] cap_pc;
    logic             mis;
    assign next_pc = bus.controle ? bus.add_result : bus.pc4;
`ifdef PCSRC_ALIGN_CHECK_EN
    assign cap_pc = {next_pc[WIDTH-1:2], 2'b00};
    assign mis    = |next_pc[1:0];
`else
    assign cap_pc = next_pc;
    assign mis    = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.saida_pc    <= RST_PC;
            bus.sel_q       <= 1'b0;
            bus.taken_count <= '0;
            bus.misaligned  <= 1'b0;
        end else begin
            bus.saida_pc   <= cap_pc;
            bus.sel_q      <= bus.controle;
            bus.misaligned <= mis;
            // counter sticks at all-ones rather than wrapping
            if (bus.controle && !(&bus.taken_count))
                bus.taken_count <= bus.taken_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_mux_pc_src.sv
// tb_mux_pc_src: directed self-checking bench for mux_pc_src (default and 4-bit counter instances).
module tb_mux_pc_src;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mux_pc_src_if #(.WIDTH(32), .COUNT_WIDTH(16)) bus ();
    mux_pc_src_if #(.WIDTH(32), .COUNT_WIDTH(4))  bus4 ();

    assign bus4.pc4        = bus.pc4;
    assign bus4.add_result = bus.add_result;
    assign bus4.controle   = bus.controle;

    mux_pc_src #(.WIDTH(32), .RESET_VALUE(32'h0), .COUNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    mux_pc_src #(.WIDTH(32), .RESET_VALUE(32'h0), .COUNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_pc(input logic [31:0] v);
`ifdef PCSRC_ALIGN_CHECK_EN
        return {v[31:2], 2'b00};
`else
        return v;
`endif
    endfunction

    function automatic logic exp_mis(input logic [31:0] v);
`ifdef PCSRC_ALIGN_CHECK_EN
        return |v[1:0];
`else
        return 1'b0 & v[0];
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.pc4        = $urandom;
            bus.add_result = $urandom;
            bus.controle   = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (bus.saida_pc !== 32'h0) begin
                errors++;
                $display("FAIL reset_pc got %h exp 00000000", bus.saida_pc);
            end
            checks++;
            if (bus.sel_q !== 1'b0) begin
                errors++;
                $display("FAIL reset_sel got %b exp 0", bus.sel_q);
            end
            checks++;
            if (bus.taken_count !== 16'd0 || bus4.taken_count !== 4'd0) begin
                errors++;
                $display("FAIL reset_count got %0d/%0d exp 0", bus.taken_count, bus4.taken_count);
            end
            checks++;
            if (bus.misaligned !== 1'b0) begin
                errors++;
                $display("FAIL reset_mis got %b exp 0", bus.misaligned);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        bus.pc4 = 32'd1010;
        bus.add_result = 32'd1111;
        bus.controle = 1'b0;
        step();
        checks++;
        if (bus.saida_pc !== exp_pc(32'd1010) || bus.sel_q !== 1'b0) begin
            errors++;
            $display("FAIL seq_pc got %0d sel %b exp %0d sel 0", bus.saida_pc, bus.sel_q, exp_pc(32'd1010));
        end
        checks++;
        if (bus.taken_count !== 16'd0) begin
            errors++;
            $display("FAIL seq_count got %0d exp 0", bus.taken_count);
        end
    endtask

    task automatic test_branch();
        bus.controle = 1'b1;
        step();
        checks++;
        if (bus.saida_pc !== exp_pc(32'd1111) || bus.sel_q !== 1'b1) begin
            errors++;
            $display("FAIL branch_pc got %0d sel %b exp %0d sel 1", bus.saida_pc, bus.sel_q, exp_pc(32'd1111));
        end
        checks++;
        if (bus.taken_count !== 16'd1) begin
            errors++;
            $display("FAIL branch_count got %0d exp 1", bus.taken_count);
        end
        checks++;
        if (bus.misaligned !== exp_mis(32'd1111)) begin
            errors++;
            $display("FAIL branch_mis got %b exp %b", bus.misaligned, exp_mis(32'd1111));
        end
    endtask

    task automatic test_latency();
        bus.controle = 1'b0;
        #3;
        checks++;
        if (bus.saida_pc !== exp_pc(32'd1111) || bus.sel_q !== 1'b1) begin
            errors++;
            $display("FAIL latency_hold got %0d sel %b exp %0d sel 1", bus.saida_pc, bus.sel_q, exp_pc(32'd1111));
        end
        step();
        checks++;
        if (bus.saida_pc !== exp_pc(32'd1010) || bus.sel_q !== 1'b0 || bus.taken_count !== 16'd1) begin
            errors++;
            $display("FAIL latency_capture got %0d sel %b cnt %0d exp %0d sel 0 cnt 1",
                     bus.saida_pc, bus.sel_q, bus.taken_count, exp_pc(32'd1010));
        end
    endtask

    task automatic test_equal_inputs();
        bus.pc4 = 32'd2000;
        bus.add_result = 32'd2000;
        bus.controle = 1'b1;
        step();
        checks++;
        if (bus.saida_pc !== 32'd2000 || bus.taken_count !== 16'd2) begin
            errors++;
            $display("FAIL equal_taken got %0d cnt %0d exp 2000 cnt 2", bus.saida_pc, bus.taken_count);
        end
        bus.controle = 1'b0;
        step();
        checks++;
        if (bus.saida_pc !== 32'd2000 || bus.taken_count !== 16'd2) begin
            errors++;
            $display("FAIL equal_not_taken got %0d cnt %0d exp 2000 cnt 2", bus.saida_pc, bus.taken_count);
        end
    endtask

    task automatic test_async_reset();
        bus.controle = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.pc4 = 32'h40 + 32'(i * 4);
            bus.add_result = 32'h80 + 32'(i * 4);
            step();
        end
        checks++;
        if (bus.taken_count !== 16'd5 || bus.saida_pc !== 32'h88) begin
            errors++;
            $display("FAIL pre_reset got cnt %0d pc %h exp cnt 5 pc 00000088", bus.taken_count, bus.saida_pc);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.saida_pc !== 32'h0 || bus.sel_q !== 1'b0 || bus.taken_count !== 16'd0 || bus.misaligned !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got pc %h sel %b cnt %0d mis %b exp all 0",
                     bus.saida_pc, bus.sel_q, bus.taken_count, bus.misaligned);
        end
        step();
        checks++;
        if (bus.saida_pc !== 32'h0 || bus.taken_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_hold got pc %h cnt %0d exp 0", bus.saida_pc, bus.taken_count);
        end
        rst_n = 1'b1;
        bus.pc4 = 32'h100;
        bus.add_result = 32'h200;
        step();
        checks++;
        if (bus.saida_pc !== 32'h200 || bus.sel_q !== 1'b1 || bus.taken_count !== 16'd1) begin
            errors++;
            $display("FAIL post_reset got pc %h sel %b cnt %0d exp 00000200 sel 1 cnt 1",
                     bus.saida_pc, bus.sel_q, bus.taken_count);
        end
    endtask

    task automatic test_saturation();
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        bus.controle = 1'b1;
        bus.pc4 = 32'h300;
        bus.add_result = 32'h400;
        for (int i = 1; i <= 20; i++) begin
            step();
            checks++;
            if (bus4.taken_count !== 4'(i > 15 ? 15 : i) || bus.taken_count !== 16'(i)) begin
                errors++;
                $display("FAIL sat_edge%0d got %0d/%0d exp %0d/%0d",
                         i, bus4.taken_count, bus.taken_count, (i > 15 ? 15 : i), i);
            end
        end
        checks++;
        if (bus4.saida_pc !== 32'h400) begin
            errors++;
            $display("FAIL sat_pc got %h exp 00000400", bus4.saida_pc);
        end
        bus.controle = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus4.taken_count !== 4'd15 || bus.taken_count !== 16'd20) begin
                errors++;
                $display("FAIL sat_hold got %0d/%0d exp 15/20", bus4.taken_count, bus.taken_count);
            end
        end
    endtask

    initial begin
        bus.pc4 = '0;
        bus.add_result = '0;
        bus.controle = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_latency();
        test_equal_inputs();
        test_async_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
